// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_pkg;

    localparam int ADDR_W    = 4;
    localparam int REG_COUNT = 16;
    localparam int CNT_W     = 16;

    // Shadow stage indices
    localparam int EX       = 0;
    localparam int MEM      = 1;
    localparam int WB       = 2;
    localparam int N_STAGES = 3;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    // mem_access covers both loads and stores; only loads set mem_read
    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic [ADDR_W-1:0] rd;
        logic              mem_read;
        logic              mem_access;
    } shadow_t;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// rtl/hazard_stall_ctrl_if.sv - ID-stage request and stall-control bundle
// master: pipeline side, drives the ID instruction, mem_ready and flush
// slave : hazard controller, returns stall_if_id/bubble_ex/hold, busy_mask, stall_count
interface hazard_stall_ctrl_if #(
    parameter int REG_COUNT = hazard_pkg::REG_COUNT,
    parameter int ADDR_W    = hazard_pkg::ADDR_W,
    parameter int CNT_W     = hazard_pkg::CNT_W
);
    logic                 id_valid;
    logic [ADDR_W-1:0]    id_rs;
    logic [ADDR_W-1:0]    id_rt;
    logic                 id_use_rs;
    logic                 id_use_rt;
    logic                 id_reg_write;
    logic [ADDR_W-1:0]    id_rd;
    logic                 id_mem_read;
    logic                 id_mem_write;
    logic                 mem_ready;
    logic                 flush;
    logic                 stall_if_id;
    logic                 bubble_ex;
    logic                 hold;
    logic [REG_COUNT-1:0] busy_mask;
    logic [CNT_W-1:0]     stall_count;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_reg_write,
               id_rd, id_mem_read, id_mem_write, mem_ready, flush,
        input  stall_if_id, bubble_ex, hold, busy_mask, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_reg_write,
               id_rd, id_mem_read, id_mem_write, mem_ready, flush,
        output stall_if_id, bubble_ex, hold, busy_mask, stall_count
    );
endinterface

// File: rtl/hazard_addr_match.sv
// rtl/hazard_addr_match.sv - register address compare with zero-register exclusion
// i_use   : compare enable
// i_a/i_b : register addresses
// o_match : i_use and equal addresses and address nonzero
module hazard_addr_match #(
    parameter int ADDR_W = 4
) (
    input  logic              i_use,
    input  logic [ADDR_W-1:0] i_a,
    input  logic [ADDR_W-1:0] i_b,
    output logic              o_match
);
    // r0 is hard-wired zero: it is never a real producer or consumer
    assign o_match = i_use && (i_a == i_b) && (i_a != '0);
endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use / memory-wait stall controller for the 5-stage core
// clk, rst_n : core clock, asynchronous active-low reset
// bus        : slave side of hazard_stall_ctrl_if (ID instruction, mem_ready, flush in;
//              stall_if_id, bubble_ex, hold, busy_mask, stall_count out)
// Parameter values must match those of the connected interface instance.
module hazard_stall_ctrl #(
    parameter int REG_COUNT = hazard_pkg::REG_COUNT,
    parameter int ADDR_W    = hazard_pkg::ADDR_W,
    parameter int CNT_W     = hazard_pkg::CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    hazard_stall_ctrl_if.slave bus
);

    hazard_pkg::shadow_t  r_stage [hazard_pkg::N_STAGES];
    hazard_pkg::state_t   r_state;
    hazard_pkg::state_t   w_state_nxt;
    logic [CNT_W-1:0]     r_stall_count;

    hazard_pkg::shadow_t  w_id_entry;
    logic                 w_match_rs;
    logic                 w_match_rt;
    logic                 w_mem_wait;
    logic                 w_lu_hit;
    logic                 w_stall_if_id;
    logic                 w_bubble_ex;
    logic                 w_hold;
    logic [hazard_pkg::N_STAGES*REG_COUNT-1:0] w_stage_hit;
    logic [REG_COUNT-1:0] w_busy_mask;

    // Source compares against the load sitting in the EX shadow
    hazard_addr_match #(.ADDR_W(ADDR_W)) u_match_rs (
        .i_use   (bus.id_use_rs),
        .i_a     (bus.id_rs),
        .i_b     (r_stage[hazard_pkg::EX].rd),
        .o_match (w_match_rs)
    );

    hazard_addr_match #(.ADDR_W(ADDR_W)) u_match_rt (
        .i_use   (bus.id_use_rt),
        .i_a     (bus.id_rt),
        .i_b     (r_stage[hazard_pkg::EX].rd),
        .o_match (w_match_rt)
    );

    // One-hot decode of each in-flight destination; r0 drops out in the matcher
    for (genvar s = 0; s < hazard_pkg::N_STAGES; s++) begin : g_stage
        for (genvar r = 0; r < REG_COUNT; r++) begin : g_reg
            hazard_addr_match #(.ADDR_W(ADDR_W)) u_busy (
                .i_use   (r_stage[s].valid & r_stage[s].reg_write),
                .i_a     (r_stage[s].rd),
                .i_b     (ADDR_W'(r)),
                .o_match (w_stage_hit[s*REG_COUNT+r])
            );
        end
    end

    always_comb begin
        w_busy_mask = '0;
        for (int s = 0; s < hazard_pkg::N_STAGES; s++) begin
            w_busy_mask = w_busy_mask | w_stage_hit[s*REG_COUNT +: REG_COUNT];
        end
        w_busy_mask[0] = 1'b0;
    end

    // Stall priority: memory wait, then flush, then load-use
    always_comb begin
        w_mem_wait    = r_stage[hazard_pkg::MEM].valid &&
                        r_stage[hazard_pkg::MEM].mem_access && !bus.mem_ready;
        w_lu_hit      = bus.id_valid && r_stage[hazard_pkg::EX].valid &&
                        r_stage[hazard_pkg::EX].mem_read && (w_match_rs || w_match_rt);
        w_hold        = 1'b0;
        w_stall_if_id = 1'b0;
        w_bubble_ex   = 1'b0;
        if (w_mem_wait) begin
            // flush comes from the frozen EX stage, so dropping it here is safe
            w_hold        = 1'b1;
            w_stall_if_id = 1'b1;
        end else if (bus.flush) begin
            w_bubble_ex   = 1'b1;
        end else if (w_lu_hit) begin
            w_stall_if_id = 1'b1;
            w_bubble_ex   = 1'b1;
        end
    end

    always_comb begin
        w_id_entry = '0;
        if (bus.id_valid && !w_stall_if_id && !w_bubble_ex && !w_hold) begin
            w_id_entry.valid      = 1'b1;
            w_id_entry.reg_write  = bus.id_reg_write;
            w_id_entry.rd         = bus.id_rd;
            w_id_entry.mem_read   = bus.id_mem_read;
            w_id_entry.mem_access = bus.id_mem_read | bus.id_mem_write;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            hazard_pkg::RUN: begin
                if (w_mem_wait) begin
                    w_state_nxt = hazard_pkg::MEM_WAIT;
                end else if (w_lu_hit && !bus.flush) begin
                    w_state_nxt = hazard_pkg::LU_STALL;
                end
            end
            hazard_pkg::LU_STALL: begin
                w_state_nxt = w_mem_wait ? hazard_pkg::MEM_WAIT : hazard_pkg::RUN;
            end
            hazard_pkg::MEM_WAIT: begin
                if (!w_mem_wait) begin
                    w_state_nxt = hazard_pkg::RUN;
                end
            end
            default: w_state_nxt = hazard_pkg::RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= hazard_pkg::RUN;
            r_stall_count <= '0;
            for (int s = 0; s < hazard_pkg::N_STAGES; s++) begin
                r_stage[s] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (w_hold) begin
                // EX/MEM freeze; MEM/WB receives a bubble
                r_stage[hazard_pkg::WB]  <= '0;
            end else begin
                r_stage[hazard_pkg::WB]  <= r_stage[hazard_pkg::MEM];
                r_stage[hazard_pkg::MEM] <= r_stage[hazard_pkg::EX];
                r_stage[hazard_pkg::EX]  <= w_id_entry;
            end
            if ((w_stall_if_id || w_hold) && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
        end
    end

    assign bus.stall_if_id = w_stall_if_id;
    assign bus.bubble_ex   = w_bubble_ex;
    assign bus.hold        = w_hold;
    assign bus.busy_mask   = w_busy_mask;
    assign bus.stall_count = r_stall_count;

endmodule
